// File: rtl/da_lut_loader.sv
// da_lut_loader: collects raw FIR taps and bursts the expanded DA partial-sum LUTs out over CIN/CADDR/CLOAD.
module da_lut_loader #(
  parameter int COEF_W = 16,
  parameter int OUT_W  = 20,
  parameter int NGROUP = 8,
  localparam int NTAP  = NGROUP * 8,
  localparam int AW    = $clog2(NGROUP) + 8,
  localparam int CW    = $clog2(NTAP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [OUT_W-1:0]  CIN,
  output logic [AW-1:0]     CADDR,
  output logic              CLOAD,
  output logic              busy,
  output logic              done
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     ccnt_q;
  logic [AW-1:0]     wcnt_q;
  logic [COEF_W-1:0] tap_q [NTAP];
  logic [OUT_W-1:0]  cin_q, sum;
  logic [AW-1:0]     caddr_q;
  logic              cload_q, done_q, hs;
  logic [AW-9:0]     grp;
  assign coef_ready = state_q == COLLECT;
  assign busy       = state_q != IDLE;
  assign hs         = coef_valid && coef_ready;
  assign grp        = wcnt_q[AW-1:8];
  assign CIN        = cin_q;
  assign CADDR      = caddr_q;
  assign CLOAD      = cload_q;
  assign done       = done_q;
  assign state_d = (state_q == IDLE && start) ? COLLECT :
                   (state_q == COLLECT && hs && ccnt_q == CW'(NTAP - 1)) ? WRITE :
                   (state_q == WRITE && &wcnt_q) ? DONE :
                   (state_q == DONE) ? IDLE : state_q;
  // partial sum for the entry addressed by wcnt: low 8 bits pick taps within the group
  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++)
      if (wcnt_q[i]) sum = sum + {{(OUT_W-COEF_W){tap_q[{grp, 3'(i)}][COEF_W-1]}}, tap_q[{grp, 3'(i)}]};
  end
  always_ff @(posedge clk)
    if (hs) tap_q[ccnt_q] <= coef_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ccnt_q  <= '0;
      wcnt_q  <= '0;
      cin_q   <= '0;
      caddr_q <= '0;
      cload_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cload_q <= state_q == WRITE;
      done_q  <= state_q == DONE;
      ccnt_q  <= state_q == IDLE ? '0 : hs ? ccnt_q + CW'(1) : ccnt_q;
      wcnt_q  <= state_q == WRITE ? wcnt_q + AW'(1) : '0;
      if (state_q == WRITE) begin
        caddr_q <= wcnt_q;
        cin_q   <= sum;
      end
    end
  end
endmodule

// File: tb/tb_da_lut_loader.sv
// tb_da_lut_loader: randomized load runs of da_lut_loader against a per-entry partial-sum model.
module tb_da_lut_loader;
  logic        clk = 0, reset = 1, start = 0, coef_valid = 0;
  logic [15:0] coef_in = '0;
  logic        coef_ready, CLOAD, busy, done;
  logic [19:0] CIN;
  logic [10:0] CADDR;
  int          total = 0, bad = 0;
  int          tap [64];
  logic [19:0] cap [2048], ref_cap [2048];

  da_lut_loader dut (
    .clk(clk), .reset(reset), .start(start), .coef_in(coef_in), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .CIN(CIN), .CADDR(CADDR), .CLOAD(CLOAD), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model(input int a);
    int s = 0;
    for (int i = 0; i < 8; i++)
      if (a[i]) s += tap[(a >> 8) * 8 + i];
    return s[19:0];
  endfunction

  task automatic run(input bit stall, input bit noise, input int abort_at);
    int n = 0, k = 0, dn = 0, cyc = 0;
    bit hs;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    check("busy_after_start", busy, 1);
    while (n < 64 && cyc < 2000) begin
      coef_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_in    = coef_valid ? 16'(tap[n]) : 16'($urandom);
      start      = noise && n == 30;
      #1 hs = coef_valid && coef_ready;
      @(negedge clk);
      if (hs) n++;
      cyc++;
    end
    coef_valid = 0;
    start = 0;
    check("taps_taken", n, 64);
    cyc = 0;
    while (cyc < 2200) begin
      if (CLOAD) begin
        check("caddr", CADDR, k);
        check("cin", CIN, model(k));
        check("done_low_in_burst", done, 0);
        cap[k] = CIN;
        k++;
        if (k == abort_at) begin
          reset = 1;
          @(negedge clk); reset = 0;
          check("abort_cload", CLOAD, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          repeat (5) begin
            @(negedge clk);
            dn += int'(done);
          end
          check("abort_no_done", dn, 0);
          return;
        end
        start = noise && k == 500;
      end else if (k > 0) break;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    check("write_count", k, 2048);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
    check("cload_idle", CLOAD, 0);
  endtask

  initial begin
    int diff;
    repeat (3) @(negedge clk);
    check("rst_cin", CIN, 0);
    check("rst_caddr", CADDR, 0);
    check("rst_cload", CLOAD, 0);
    check("rst_ready", coef_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 0;
    for (int n = 0; n < 64; n++) tap[n] = n + 1;
    run(0, 0, 0);
    ref_cap = cap;
    check("ramp_0ff", cap[11'h0FF], 36);
    check("ramp_701", cap[11'h701], 57);
    check("ramp_000", cap[11'h000], 0);
    check("ramp_7ff", cap[11'h7FF], 484);
    run(1, 1, 0);
    diff = 0;
    for (int a = 0; a < 2048; a++) if (cap[a] !== ref_cap[a]) diff++;
    check("stall_vs_nostall", diff, 0);
    for (int n = 0; n < 64; n++) tap[n] = $signed(16'($urandom));
    run(0, 0, 1000);
    for (int n = 0; n < 64; n++) tap[n] = $signed(16'($urandom));
    run(1, 0, 0);
    for (int n = 0; n < 64; n++) tap[n] = -32768;
    run(0, 0, 0);
    check("neg_3ff", cap[11'h3FF], 20'hC0000);
    check("neg_301", cap[11'h301], 20'hF8000);
    for (int n = 0; n < 64; n++) tap[n] = 32767;
    run(0, 1, 0);
    check("pos_0ff", cap[11'h0FF], 20'h3FFF8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
